// File: rtl/jk_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jk_pkg: FSM states and JK opcode constants.  Rev 1.0             |
// +------------------------------------------------------------------+
package jk_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // {J,K} encodings as seen by one flip-flop of the bank
  localparam logic [1:0] HOLD = 2'b00;
  localparam logic [1:0] RST  = 2'b01;
  localparam logic [1:0] SET  = 2'b10;
  localparam logic [1:0] TGL  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/jk_excite.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jk_excite: inverse JK table, cur/nxt word to J/K word.  Rev 1.0  |
// +------------------------------------------------------------------+
module jk_excite
  import jk_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit FILL_ONES = 1'b0
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] nxt,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K
);

  generate
    if (FILL_ONES) begin : g_toggle
      // don't-cares resolved to 1: changing bits toggle, steady bits set/reset
      assign J = nxt | cur;
      assign K = ~(cur & nxt);
    end else begin : g_setrst
      assign J = nxt & ~cur;
      assign K = cur & ~nxt;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/jk_target_loader.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jk_target_loader: drives a JK bank to a target word with         |
// | readback and bounded retry.  Rev 1.0                             |
// +------------------------------------------------------------------+
module jk_target_loader
  import jk_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_RETRY = 3,
  parameter bit FILL_ONES = 1'b0
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] Q_fb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] err_mask
);

  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] c_RETRY_LIMIT = RW'(MAX_RETRY);

  state_t           r_state;
  logic [RW-1:0]    r_retry;
  logic [WIDTH-1:0] r_target;
  logic [WIDTH-1:0] w_nxt;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;

  // In IDLE the excitation must be ready on the accept edge, before the latch
  assign w_nxt = (r_state == IDLE) ? tgt_data : r_target;

  jk_excite #(
    .WIDTH     (WIDTH),
    .FILL_ONES (FILL_ONES)
  ) u_excite (
    .cur (Q_fb),
    .nxt (w_nxt),
    .J   (w_j),
    .K   (w_k)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state   <= IDLE;
      r_retry   <= '0;
      r_target  <= '0;
      tgt_ready <= 1'b1;
      J         <= '0;
      K         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_mask  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          J <= '0;
          K <= '0;
          if (tgt_valid && tgt_ready) begin
            r_target  <= tgt_data;
            r_retry   <= '0;
            err_mask  <= '0;
            J         <= w_j;
            K         <= w_k;
            tgt_ready <= 1'b0;
            busy      <= 1'b1;
            r_state   <= DRIVE;
          end
        end
        DRIVE: begin
          J       <= '0;
          K       <= '0;
          r_state <= CHECK;
        end
        CHECK: begin
          if (Q_fb == r_target) begin
            done    <= 1'b1;
            err     <= 1'b0;
            r_state <= DONE;
          end else if (r_retry < c_RETRY_LIMIT) begin
            r_retry <= r_retry + 1'b1;
            J       <= w_j;
            K       <= w_k;
            r_state <= DRIVE;
          end else begin
            done     <= 1'b1;
            err      <= 1'b1;
            err_mask <= Q_fb ^ r_target;
            r_state  <= DONE;
          end
        end
        DONE: begin
          done      <= 1'b0;
          err       <= 1'b0;
          busy      <= 1'b0;
          tgt_ready <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
